demux_16_buf: RTL and testbench

//  Registered 1-to-2 demultiplexer with valid/ready handshake; the inverse of the 16-bit 2:1 select mux.

---
 rtl/demux_16_buf_pkg.sv | 11 +
 rtl/demux_slot.sv | 53 +++++
 rtl/demux_16_buf.sv | 69 ++++++
 tb/tb_demux_16_buf.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_16_buf_pkg.sv
// Shared defaults and slot state encoding for the 1-to-2 buffered demultiplexer.
package demux_16_buf_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 8;
    localparam int NUM_CH    = 2;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/demux_slot.sv
// Single-entry output buffer: EMPTY/FULL state, held data word and delivered-word counter.
module demux_slot
    import demux_16_buf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_ready,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_cnt
);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;
    logic             w_drain;

    assign w_drain = (r_state == ST_FULL) && i_rd_ready;
    // A full slot can still take a word when its consumer drains in the same cycle.
    assign o_ready = (r_state == ST_EMPTY) || i_rd_ready;
    assign o_data  = r_data;
    assign o_valid = (r_state == ST_FULL);
    assign o_cnt   = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_cnt   <= '0;
        end else if (i_clr) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_drain)
                r_cnt <= r_cnt + CNT_W'(1);
            if (i_wr_en) begin
                r_state <= ST_FULL;
                r_data  <= i_wr_data;
            end else if (w_drain) begin
                r_state <= ST_EMPTY;
            end
        end
    end

endmodule

// File: rtl/demux_16_buf.sv
// Registered 1-to-2 demultiplexer: steers each accepted word into one of two independent output buffers.
module demux_16_buf
    import demux_16_buf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic [NUM_CH-1:0]            w_rd_ready;
    logic [NUM_CH-1:0]            w_slot_rdy;
    logic [NUM_CH-1:0]            w_wr_en;
    logic [NUM_CH-1:0]            w_valid;
    logic [NUM_CH-1:0][WIDTH-1:0] w_data;
    logic [NUM_CH-1:0][CNT_W-1:0] w_cnt;
    logic                         w_accept;

    assign w_rd_ready = {out1_ready, out0_ready};

    // clr wins over everything, so the source is held off for that cycle.
    assign in_ready = !clr && w_slot_rdy[in_sel];
    assign w_accept = in_valid && in_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
        assign w_wr_en[g] = w_accept && (in_sel == 1'(g));

        demux_slot #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_clr      (clr),
            .i_wr_en    (w_wr_en[g]),
            .i_wr_data  (in_data),
            .i_rd_ready (w_rd_ready[g]),
            .o_ready    (w_slot_rdy[g]),
            .o_data     (w_data[g]),
            .o_valid    (w_valid[g]),
            .o_cnt      (w_cnt[g])
        );
    end

    assign out0_data  = w_data[0];
    assign out1_data  = w_data[1];
    assign out0_valid = w_valid[0];
    assign out1_valid = w_valid[1];
    assign cnt0       = w_cnt[0];
    assign cnt1       = w_cnt[1];

    a_sel_known: assert property (@(posedge clk) disable iff (!rst_n)
        in_valid |-> !$isunknown(in_sel));

endmodule

// File: tb/tb_demux_16_buf.sv
// Self-checking bench for demux_16_buf: directed scenarios plus randomized traffic against a slot model.
module tb_demux_16_buf;

    logic        clk = 1'b0;
    logic        rst_n, clr, in_sel, in_valid, in_ready;
    logic [15:0] in_data, out0_data, out1_data;
    logic        out0_valid, out0_ready, out1_valid, out1_ready;
    logic [7:0]  cnt0, cnt1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: per-channel occupancy, held word, delivered count (unbounded int).
    bit        m_full [2];
    bit [15:0] m_data [2];
    int        m_cnt  [2];

    always #5 clk = ~clk;

    demux_16_buf dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    function automatic bit m_in_ready();
        bit rdy = (in_sel == 1'b0) ? out0_ready : out1_ready;
        return !clr && (!m_full[in_sel] || rdy);
    endfunction

    task automatic m_clear();
        for (int n = 0; n < 2; n++) begin
            m_full[n] = 0; m_data[n] = '0; m_cnt[n] = 0;
        end
    endtask

    // Advance one clock: update the model from the inputs held across the edge, return at negedge.
    task automatic cyc();
        bit acc;
        bit dr [2];
        acc   = in_valid && m_in_ready();
        dr[0] = m_full[0] && out0_ready;
        dr[1] = m_full[1] && out1_ready;
        @(posedge clk);
        if (clr) begin
            m_clear();
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (dr[n]) m_cnt[n]++;
                if (acc && in_sel == 1'(n)) begin
                    m_full[n] = 1; m_data[n] = in_data;
                end else if (dr[n]) begin
                    m_full[n] = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        clr = 0; in_valid = 0; in_sel = 0; in_data = '0; out0_ready = 0; out1_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        m_clear();
        #12;
        n_cmp += 4;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid: got %b%b want 00", out1_valid, out0_valid);
        end
        if (out0_data !== 16'h0 || out1_data !== 16'h0) begin
            n_bad++; $display("FAIL reset_data: got %h/%h want 0000/0000", out0_data, out1_data);
        end
        if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
            n_bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", cnt0, cnt1);
        end
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        in_sel = 0; in_data = 16'hA5A5; in_valid = 1; out0_ready = 1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL basic_in_ready: got %b want 1", in_ready);
        end
        cyc();
        in_valid = 0;
        #1;
        n_cmp += 2;
        if (out0_valid !== 1'b1 || out0_data !== 16'hA5A5) begin
            n_bad++; $display("FAIL basic_out0: got v=%b d=%h want v=1 d=a5a5", out0_valid, out0_data);
        end
        if (out1_valid !== 1'b0) begin
            n_bad++; $display("FAIL basic_out1_idle: got %b want 0", out1_valid);
        end
        cyc();
        #1;
        n_cmp++;
        if (cnt0 !== 8'd1 || out0_valid !== 1'b0) begin
            n_bad++; $display("FAIL basic_cnt0: got cnt=%0d v=%b want cnt=1 v=0", cnt0, out0_valid);
        end
        out0_ready = 0;
    endtask

    task automatic test_stall();
        out1_ready = 0; in_sel = 1; in_data = 16'h1111; in_valid = 1;
        cyc();
        in_data = 16'h2222;
        #1;
        n_cmp += 2;
        if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL stall_in_ready: got %b want 0", in_ready);
        end
        if (out1_valid !== 1'b1 || out1_data !== 16'h1111) begin
            n_bad++; $display("FAIL stall_hold: got v=%b d=%h want v=1 d=1111", out1_valid, out1_data);
        end
        cyc();
        #1;
        n_cmp++;
        if (out1_data !== 16'h1111 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL stall_hold2: got d=%h rdy=%b want d=1111 rdy=0", out1_data, in_ready);
        end
        out1_ready = 1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL stall_refill_ready: got %b want 1", in_ready);
        end
        cyc();
        in_valid = 0; out1_ready = 0;
        #1;
        n_cmp++;
        if (out1_data !== 16'h2222 || out1_valid !== 1'b1 || cnt1 !== 8'd1) begin
            n_bad++; $display("FAIL stall_refill: got d=%h v=%b cnt1=%0d want d=2222 v=1 cnt1=1",
                              out1_data, out1_valid, cnt1);
        end
    endtask

    task automatic test_switch();
        out1_ready = 1;
        cyc();
        out1_ready = 0; out0_ready = 0;
        in_sel = 0; in_data = 16'h0BAD; in_valid = 1;
        cyc();
        in_data = 16'h1234;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL switch_blocked: got %b want 0", in_ready);
        end
        cyc();
        in_sel = 1; in_data = 16'h00FF;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL switch_ready: got %b want 1", in_ready);
        end
        cyc();
        in_valid = 0;
        #1;
        n_cmp += 2;
        if (out1_valid !== 1'b1 || out1_data !== 16'h00FF) begin
            n_bad++; $display("FAIL switch_out1: got v=%b d=%h want v=1 d=00ff", out1_valid, out1_data);
        end
        if (out0_valid !== 1'b1 || out0_data !== 16'h0BAD) begin
            n_bad++; $display("FAIL switch_out0_kept: got v=%b d=%h want v=1 d=0bad", out0_valid, out0_data);
        end
    endtask

    task automatic test_back_to_back();
        bit [15:0] words [300];
        int        bad_rdy = 0;
        int        bad_dat = 0;
        clr = 1;
        cyc();
        clr = 0;
        out0_ready = 1; in_sel = 0; in_valid = 1;
        for (int k = 0; k < 300; k++) begin
            words[k] = 16'($urandom);
            in_data  = words[k];
            #1;
            if (in_ready !== 1'b1) bad_rdy++;
            if (k > 0 && (out0_valid !== 1'b1 || out0_data !== words[k-1])) bad_dat++;
            cyc();
        end
        in_valid = 0;
        #1;
        n_cmp += 3;
        if (bad_rdy != 0) begin
            n_bad++; $display("FAIL b2b_ready: %0d stalled cycles, want 0", bad_rdy);
        end
        if (bad_dat != 0 || out0_data !== words[299]) begin
            n_bad++; $display("FAIL b2b_order: %0d bad words, last=%h want %h", bad_dat, out0_data, words[299]);
        end
        cyc();
        #1;
        if (cnt0 !== 8'd44) begin
            n_bad++; $display("FAIL b2b_cnt0: got %0d want 44", cnt0);
        end
        out0_ready = 0;
    endtask

    task automatic test_clr();
        in_valid = 1; in_sel = 0; in_data = 16'hC0C0;
        cyc();
        in_sel = 1; in_data = 16'hC1C1;
        cyc();
        clr = 1; out0_ready = 1; in_sel = 0; in_data = 16'hDEAD;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL clr_in_ready: got %b want 0", in_ready);
        end
        cyc();
        clr = 0; in_valid = 0; out0_ready = 0;
        #1;
        n_cmp += 3;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
            n_bad++; $display("FAIL clr_valid: got %b%b want 00", out1_valid, out0_valid);
        end
        if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
            n_bad++; $display("FAIL clr_cnt: got %0d/%0d want 0/0", cnt0, cnt1);
        end
        if (out0_data !== 16'h0 || out1_data !== 16'h0) begin
            n_bad++; $display("FAIL clr_data: got %h/%h want 0000/0000", out0_data, out1_data);
        end
    endtask

    task automatic test_async_reset();
        in_valid = 1; in_sel = 1; in_data = 16'h7777; out1_ready = 1;
        cyc();
        in_data = 16'h8888;
        cyc();
        in_valid = 0; out1_ready = 0;
        #2;
        rst_n = 0;
        #1;
        n_cmp++;
        if (out1_valid !== 1'b0 || cnt1 !== 8'd0 || out1_data !== 16'h0) begin
            n_bad++; $display("FAIL async_reset: got v=%b cnt1=%0d d=%h want v=0 cnt1=0 d=0000",
                              out1_valid, cnt1, out1_data);
        end
        m_clear();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_random();
        int errs = 0;
        int first_err = -1;
        for (int c = 0; c < 600; c++) begin
            clr        = ($urandom_range(0, 39) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_sel     = 1'($urandom);
            in_data    = 16'($urandom);
            out0_ready = ($urandom_range(0, 2) != 0);
            out1_ready = ($urandom_range(0, 1) != 0);
            #1;
            if (in_ready !== m_in_ready() ||
                out0_valid !== m_full[0] || out1_valid !== m_full[1] ||
                out0_data !== m_data[0] || out1_data !== m_data[1] ||
                cnt0 !== 8'(m_cnt[0]) || cnt1 !== 8'(m_cnt[1])) begin
                errs++;
                if (first_err < 0) begin
                    first_err = c;
                    $display("FAIL random_cycle%0d: got rdy=%b v=%b%b d=%h/%h c=%0d/%0d want rdy=%b v=%b%b d=%h/%h c=%0d/%0d",
                             c, in_ready, out1_valid, out0_valid, out0_data, out1_data, cnt0, cnt1,
                             m_in_ready(), m_full[1], m_full[0], m_data[0], m_data[1],
                             8'(m_cnt[0]), 8'(m_cnt[1]));
                end
            end
            cyc();
        end
        n_cmp++;
        if (errs != 0) begin
            n_bad++; $display("FAIL random_total: %0d bad cycles, want 0", errs);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1;
        test_reset();
        test_basic();
        test_stall();
        test_switch();
        test_back_to_back();
        test_clr();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
